// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate controller slice.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY_OPEN,
    EXIT_OPEN,
    COMMIT,
    GUARD
  } state_t;

  typedef enum logic {
    ENTRY = 1'b0,
    EXIT  = 1'b1
  } dir_t;

  localparam int DEFAULT_OPEN_TIMEOUT = 1000;
  localparam int DEFAULT_GUARD_CYCLES = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/parking_gate_controller_if.sv
// Gate sensor, barrier and occupancy-block signals bundled for the controller.
interface parking_gate_controller_if;

  logic       entry_req;
  logic       entry_is_uni;
  logic       exit_req;
  logic       exit_is_uni;
  logic       entry_pass;
  logic       exit_pass;
  logic       uni_is_vacated_space;
  logic       is_vacated_space;
  logic       uni_occupied;
  logic       occupied;

  logic       entry_gate_open;
  logic       exit_gate_open;
  logic       car_entered;
  logic       is_uni_car_entered;
  logic       car_exited;
  logic       is_uni_car_exited;
  logic       entry_denied;
  logic       exit_denied;
  logic       timeout;
  logic       busy;
  logic [7:0] timeout_count;

  // The gate/occupancy environment is the master, the controller the slave.
  modport master (
    output entry_req, entry_is_uni, exit_req, exit_is_uni,
           entry_pass, exit_pass,
           uni_is_vacated_space, is_vacated_space, uni_occupied, occupied,
    input  entry_gate_open, exit_gate_open,
           car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
           entry_denied, exit_denied, timeout, busy, timeout_count
  );

  modport slave (
    input  entry_req, entry_is_uni, exit_req, exit_is_uni,
           entry_pass, exit_pass,
           uni_is_vacated_space, is_vacated_space, uni_occupied, occupied,
    output entry_gate_open, exit_gate_open,
           car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
           entry_denied, exit_denied, timeout, busy, timeout_count
  );

endinterface

// File: rtl/parking_rr_arbiter.sv
// Two-requester round-robin: on a tie the side not served last wins.
module parking_rr_arbiter
  import parking_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_entry,
  input  logic req_exit,
  input  logic advance,
  output logic grant_valid,
  output dir_t grant_dir
);

  dir_t last_served;

  always_comb begin
    grant_valid = req_entry | req_exit;
    if (req_entry && req_exit) begin
      grant_dir = (last_served == EXIT) ? ENTRY : EXIT;
    end else if (req_entry) begin
      grant_dir = ENTRY;
    end else begin
      grant_dir = EXIT;
    end
  end

  // Resetting to EXIT hands the first tie to the entry gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_served <= EXIT;
    end else if (advance && grant_valid) begin
      last_served <= grant_dir;
    end
  end

endmodule

// File: rtl/parking_gate_controller.sv
// Sequences entry/exit barriers and issues one count pulse per car to the occupancy block.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int OPEN_TIMEOUT = DEFAULT_OPEN_TIMEOUT,
  parameter int GUARD_CYCLES = DEFAULT_GUARD_CYCLES,
  parameter int TMR_W        = 16
)
(
  input logic                      clk,
  input logic                      rst_n,
  parking_gate_controller_if.slave gate
);

  localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  state_t             state;
  dir_t               cur_dir;
  logic [TMR_W-1:0]   timer;
  logic [GUARD_W-1:0] guard_cnt;

  logic       entry_gate_open_q;
  logic       exit_gate_open_q;
  logic       car_entered_q;
  logic       car_exited_q;
  logic       is_uni_entered_q;
  logic       is_uni_exited_q;
  logic       entry_denied_q;
  logic       exit_denied_q;
  logic       timeout_q;
  logic       busy_q;
  logic [7:0] timeout_count_q;

  logic grant_valid;
  dir_t grant_dir;
  logic req_uni;
  logic check_ok;
  logic pass_seen;
  logic timer_done;
  logic guard_done;

  parking_rr_arbiter u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_entry   (gate.entry_req),
    .req_exit    (gate.exit_req),
    .advance     (state == IDLE),
    .grant_valid (grant_valid),
    .grant_dir   (grant_dir)
  );

  // Entry needs a free space of the car's class, exit needs a parked car of that class.
  always_comb begin
    req_uni    = (grant_dir == ENTRY) ? gate.entry_is_uni : gate.exit_is_uni;
    if (grant_dir == ENTRY) begin
      check_ok = req_uni ? gate.uni_is_vacated_space : gate.is_vacated_space;
    end else begin
      check_ok = req_uni ? gate.uni_occupied : gate.occupied;
    end
    pass_seen  = (cur_dir == ENTRY) ? gate.entry_pass : gate.exit_pass;
    timer_done = (timer == TMR_W'(OPEN_TIMEOUT - 1));
    guard_done = (guard_cnt == GUARD_W'(GUARD_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cur_dir           <= ENTRY;
      timer             <= '0;
      guard_cnt         <= '0;
      entry_gate_open_q <= 1'b0;
      exit_gate_open_q  <= 1'b0;
      car_entered_q     <= 1'b0;
      car_exited_q      <= 1'b0;
      is_uni_entered_q  <= 1'b0;
      is_uni_exited_q   <= 1'b0;
      entry_denied_q    <= 1'b0;
      exit_denied_q     <= 1'b0;
      timeout_q         <= 1'b0;
      busy_q            <= 1'b0;
      timeout_count_q   <= 8'd0;
    end else begin
      entry_denied_q <= 1'b0;
      exit_denied_q  <= 1'b0;
      timeout_q      <= 1'b0;
      car_entered_q  <= 1'b0;
      car_exited_q   <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_valid) begin
            cur_dir <= grant_dir;
            if (check_ok) begin
              state             <= (grant_dir == ENTRY) ? ENTRY_OPEN : EXIT_OPEN;
              timer             <= '0;
              entry_gate_open_q <= (grant_dir == ENTRY);
              exit_gate_open_q  <= (grant_dir == EXIT);
              is_uni_entered_q  <= (grant_dir == ENTRY) && req_uni;
              is_uni_exited_q   <= (grant_dir == EXIT) && req_uni;
              busy_q            <= 1'b1;
            end else begin
              entry_denied_q <= (grant_dir == ENTRY);
              exit_denied_q  <= (grant_dir == EXIT);
            end
          end
        end

        // A pass on the last open cycle still counts the car.
        ENTRY_OPEN, EXIT_OPEN: begin
          if (pass_seen) begin
            state             <= COMMIT;
            entry_gate_open_q <= 1'b0;
            exit_gate_open_q  <= 1'b0;
            car_entered_q     <= (cur_dir == ENTRY);
            car_exited_q      <= (cur_dir == EXIT);
          end else if (timer_done) begin
            state             <= GUARD;
            guard_cnt         <= '0;
            entry_gate_open_q <= 1'b0;
            exit_gate_open_q  <= 1'b0;
            timeout_q         <= 1'b1;
            timeout_count_q   <= sat_inc8(timeout_count_q);
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        COMMIT: begin
          state     <= GUARD;
          guard_cnt <= '0;
        end

        // Class flags stay valid until the occupancy block has settled.
        GUARD: begin
          if (guard_done) begin
            state            <= IDLE;
            is_uni_entered_q <= 1'b0;
            is_uni_exited_q  <= 1'b0;
            busy_q           <= 1'b0;
          end else begin
            guard_cnt <= guard_cnt + GUARD_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign gate.entry_gate_open    = entry_gate_open_q;
  assign gate.exit_gate_open     = exit_gate_open_q;
  assign gate.car_entered        = car_entered_q;
  assign gate.car_exited         = car_exited_q;
  assign gate.is_uni_car_entered = is_uni_entered_q;
  assign gate.is_uni_car_exited  = is_uni_exited_q;
  assign gate.entry_denied       = entry_denied_q;
  assign gate.exit_denied        = exit_denied_q;
  assign gate.timeout            = timeout_q;
  assign gate.busy               = busy_q;
  assign gate.timeout_count      = timeout_count_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_parking_gate_controller;

  localparam int OT = 8;
  localparam int GC = 2;

  typedef struct packed {
    bit er, eu, xr, xu, ep, xp, uvac, vac, uocc, occ;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  parking_gate_controller_if bus ();

  parking_gate_controller #(
    .OPEN_TIMEOUT (OT),
    .GUARD_CYCLES (GC),
    .TMR_W        (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .gate  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a car transaction is open -> counted -> settling, or denied outright.
  bit m_open, m_commit, m_dir, m_uni, m_last;
  int m_elapsed, m_settle, m_tcount;
  bit m_ent, m_exi, m_den_e, m_den_x, m_to;

  int n_gate, n_ent, n_exi, n_overlap, n_to, n_den_e, n_den_x, n_uni_ent, order_code;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    n_checks++;
    if (got !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_open = 0; m_commit = 0; m_dir = 0; m_uni = 0; m_last = 1;
    m_elapsed = 0; m_settle = 0; m_tcount = 0;
    m_ent = 0; m_exi = 0; m_den_e = 0; m_den_x = 0; m_to = 0;
  endtask

  task automatic modelStep(input stim_t s);
    bit want_exit, cls, ok;
    m_ent = 0; m_exi = 0; m_den_e = 0; m_den_x = 0; m_to = 0;
    if (m_open) begin
      if ((m_dir == 0 && s.ep) || (m_dir == 1 && s.xp)) begin
        m_open = 0; m_commit = 1;
        if (m_dir == 0) m_ent = 1; else m_exi = 1;
      end else if (m_elapsed == OT - 1) begin
        m_open = 0; m_settle = GC; m_to = 1;
        if (m_tcount < 255) m_tcount++;
      end else begin
        m_elapsed++;
      end
    end else if (m_commit) begin
      m_commit = 0; m_settle = GC;
    end else if (m_settle > 0) begin
      m_settle--;
    end else if (s.er || s.xr) begin
      want_exit = (s.er && s.xr) ? (m_last == 0) : s.xr;
      cls = want_exit ? s.xu : s.eu;
      ok = want_exit ? (cls ? s.uocc : s.occ) : (cls ? s.uvac : s.vac);
      m_last = want_exit; m_dir = want_exit; m_uni = cls;
      if (ok) begin
        m_open = 1; m_elapsed = 0;
      end else if (want_exit) begin
        m_den_x = 1;
      end else begin
        m_den_e = 1;
      end
    end
  endtask

  task automatic compareAll();
    bit busy;
    busy = m_open || m_commit || (m_settle > 0);
    checkOutput("gates",
      {bus.entry_gate_open, bus.exit_gate_open, bus.busy, bus.is_uni_car_entered, bus.is_uni_car_exited},
      {m_open && !m_dir, m_open && m_dir, busy, busy && !m_dir && m_uni, busy && m_dir && m_uni});
    checkOutput("pulses",
      {bus.car_entered, bus.car_exited, bus.entry_denied, bus.exit_denied, bus.timeout},
      {m_ent, m_exi, m_den_e, m_den_x, m_to});
    checkOutput("tcount", bus.timeout_count, m_tcount);
    if (bus.entry_gate_open || bus.exit_gate_open) n_gate++;
    if (bus.car_entered) begin n_ent++; order_code = order_code * 2; end
    if (bus.car_exited) begin n_exi++; order_code = order_code * 2 + 1; end
    if (bus.car_entered && bus.car_exited) n_overlap++;
    if (bus.timeout) n_to++;
    if (bus.entry_denied) n_den_e++;
    if (bus.exit_denied) n_den_x++;
    if (bus.is_uni_car_entered) n_uni_ent++;
  endtask

  task automatic clearCounters();
    n_gate = 0; n_ent = 0; n_exi = 0; n_overlap = 0; n_to = 0;
    n_den_e = 0; n_den_x = 0; n_uni_ent = 0; order_code = 0;
  endtask

  task automatic driveInputs(input stim_t s);
    bus.entry_req = s.er; bus.entry_is_uni = s.eu;
    bus.exit_req = s.xr; bus.exit_is_uni = s.xu;
    bus.entry_pass = s.ep; bus.exit_pass = s.xp;
    bus.uni_is_vacated_space = s.uvac; bus.is_vacated_space = s.vac;
    bus.uni_occupied = s.uocc; bus.occupied = s.occ;
  endtask

  // Called at a falling edge: drive, let the rising edge act, check at the next falling edge.
  task automatic applyStimulus(input stim_t s);
    driveInputs(s);
    modelStep(s);
    @(negedge clk);
    compareAll();
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    driveInputs('0);
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compareAll();
    clearCounters();
  endtask

  stim_t s;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    driveInputs('0);
    @(negedge clk);
    applyReset();

    // Plain entry, pass five cycles after opening.
    s = '0; s.er = 1; s.vac = 1;
    applyStimulus(s);
    s.er = 0;
    repeat (4) applyStimulus(s);
    s.ep = 1; applyStimulus(s);
    s.ep = 0; repeat (4) applyStimulus(s);
    checkOutput("t1_gate_cycles", n_gate, 5);
    checkOutput("t1_entered", n_ent, 1);
    checkOutput("t1_uni_flag", n_uni_ent, 0);

    // Both gates requesting together: strict alternation starting with entry.
    applyReset();
    s = '1;
    repeat (16) applyStimulus(s);
    s.er = 0; s.xr = 0;
    repeat (6) applyStimulus(s);
    checkOutput("t2_entered", n_ent, 2);
    checkOutput("t2_exited", n_exi, 2);
    checkOutput("t2_overlap", n_overlap, 0);
    checkOutput("t2_order", order_code, 5);

    // University entry with no university space.
    applyReset();
    s = '0; s.er = 1; s.eu = 1; s.uvac = 0; s.vac = 1;
    applyStimulus(s);
    s.er = 0; repeat (3) applyStimulus(s);
    checkOutput("t3_denied", n_den_e, 1);
    checkOutput("t3_gate_cycles", n_gate, 0);
    checkOutput("t3_entered", n_ent, 0);

    // Timeouts, then saturation of the timeout counter.
    applyReset();
    s = '0; s.er = 1; s.vac = 1;
    applyStimulus(s);
    s.er = 0; repeat (11) applyStimulus(s);
    checkOutput("t4_gate_cycles", n_gate, OT);
    checkOutput("t4_timeouts", n_to, 1);
    checkOutput("t4_entered", n_ent, 0);
    checkOutput("t4_tcount", bus.timeout_count, 1);
    for (int i = 0; i < 299; i++) begin
      s.er = 1; applyStimulus(s);
      s.er = 0; repeat (11) applyStimulus(s);
    end
    checkOutput("t4_tcount_sat", bus.timeout_count, 255);
    checkOutput("t4_timeouts_total", n_to, 300);

    // Reset asserted while the count pulse is high.
    applyReset();
    s = '0; s.er = 1; s.vac = 1;
    applyStimulus(s);
    s.er = 0; repeat (2) applyStimulus(s);
    s.ep = 1; applyStimulus(s);
    checkOutput("t5_in_commit", bus.car_entered, 1);
    #2 rst_n = 1'b0;
    #1 checkOutput("t5_async_clear",
      {bus.entry_gate_open, bus.exit_gate_open, bus.car_entered, bus.car_exited,
       bus.is_uni_car_entered, bus.is_uni_car_exited, bus.entry_denied, bus.exit_denied,
       bus.timeout, bus.busy, bus.timeout_count}, 0);
    applyReset();
    s = '1; applyStimulus(s);
    checkOutput("t5_tie_entry", bus.entry_gate_open, 1);
    s.er = 0; s.xr = 0; repeat (6) applyStimulus(s);

    // Exit with nothing parked, then pass on the final open cycle.
    applyReset();
    s = '0; s.xr = 1; s.occ = 0;
    applyStimulus(s);
    s.xr = 0; repeat (2) applyStimulus(s);
    checkOutput("t6_exit_denied", n_den_x, 1);
    checkOutput("t6_exited", n_exi, 0);
    clearCounters();
    s = '0; s.er = 1; s.vac = 1;
    applyStimulus(s);
    s.er = 0; repeat (OT - 1) applyStimulus(s);
    s.ep = 1; applyStimulus(s);
    s.ep = 0; repeat (4) applyStimulus(s);
    checkOutput("t6_pass_wins", n_ent, 1);
    checkOutput("t6_no_timeout", n_to, 0);

    // Random traffic against the model.
    applyReset();
    for (int i = 0; i < 1500; i++) begin
      s.er   = bit'($urandom_range(0, 1));
      s.eu   = bit'($urandom_range(0, 1));
      s.xr   = bit'($urandom_range(0, 1));
      s.xu   = bit'($urandom_range(0, 1));
      s.ep   = ($urandom_range(0, 4) == 0);
      s.xp   = ($urandom_range(0, 4) == 0);
      s.uvac = ($urandom_range(0, 3) != 0);
      s.vac  = ($urandom_range(0, 3) != 0);
      s.uocc = ($urandom_range(0, 3) != 0);
      s.occ  = ($urandom_range(0, 3) != 0);
      applyStimulus(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
